instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/riscv_fetch_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 65 ++++++
 rtl/instruction_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] word;
    } fetch_entry_t;

    function automatic logic pc_aligned(input logic [INSTR_W-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, word} entries between fetch and decode; flush wins over push/pop.
module fetch_buffer
    import riscv_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     slots [FIFO_DEPTH];

    // Payload slots carry no reset; the count alone decides what is valid.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        fetch_entry_t slot_q;
        always_ff @(posedge clk) begin
            if (push_i && !flush_i && wr_ptr_q == PTR_W'(gi)) begin
                slot_q <= push_entry_i;
            end
        end
        assign slots[gi] = slot_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = slots[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: sequential PC, redirect handling and fault stop in front of a small decode buffer.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        rom_read_address,
    input  logic [INSTR_W-1:0] rom_read_data,
    input  logic               rom_illegal_read_address,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [31:0]        instr_pc,
    output logic               fetch_fault,
    output logic [31:0]        fault_pc
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             pop;
    logic             push_slot;
    logic             pc_legal;
    logic             push;

    assign rom_read_address = pc_q;
    assign instr_valid      = (count != '0);
    assign pop              = instr_valid && instr_ready && !redirect_valid;
    // A slot exists when not full, or when the head leaves in this same cycle.
    assign push_slot        = (state_q == ST_RUN) && !redirect_valid
                              && ((count < CNT_W'(FIFO_DEPTH)) || pop);
    assign pc_legal         = pc_aligned(pc_q) && !rom_illegal_read_address;
    assign push             = push_slot && pc_legal;
    assign push_entry       = '{pc: pc_q, word: rom_read_data};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
        end else if (push_slot) begin
            if (pc_legal) begin
                pc_d = pc_q + 32'd4;
            end else begin
                state_d    = ST_FAULT;
                fault_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    // Older buffered instructions drain before the fault becomes visible.
    assign fetch_fault = (state_q == ST_FAULT) && (count == '0);
    assign fault_pc    = fault_pc_q;
    assign instr_data  = head.word;
    assign instr_pc    = head.pc;

endmodule
